// File: rtl/regfile_dump_reader_pkg.sv
// Shared definitions for the register-file dump engine and neighbouring datapath blocks.
package regfile_dump_reader_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2,
    S_DONE = 2'd3
  } dump_state_t;

  // X31 reads as zero, so the default walk stops just below it.
  localparam logic [4:0] XZR_IDX = 5'b11111;

endpackage

// File: rtl/regfile_dump_reader_if.sv
// Read-port and readout-stream bundle between the dump engine and its neighbours.
interface regfile_dump_reader_if #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ADDR_WIDTH = 5
);
  logic [ADDR_WIDTH-1:0] RA;
  logic [DATA_WIDTH-1:0] BusA;
  logic [DATA_WIDTH-1:0] OutData;
  logic [ADDR_WIDTH-1:0] OutAddr;
  logic                  OutValid;
  logic                  OutReady;

  modport master (
    output RA, OutData, OutAddr, OutValid,
    input  BusA, OutReady
  );

  modport slave (
    input  RA, OutData, OutAddr, OutValid,
    output BusA, OutReady
  );
endinterface

// File: rtl/regfile_dump_reader.sv
// Walks the register file X0..LAST_REG through a borrowed read port and streams each
// value with its index over a valid/ready handshake.
module regfile_dump_reader
  import regfile_dump_reader_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned LAST_REG   = int'(XZR_IDX) - 1,
  parameter int unsigned READ_WAIT  = 1
) (
  input  logic Clk,
  input  logic Reset_n,
  input  logic Start,
  input  logic Abort,
  output logic Busy,
  output logic Done,
  regfile_dump_reader_if.master rf
);

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(LAST_REG);
  localparam logic [3:0]            WAIT_CNT = 4'(READ_WAIT);

  dump_state_t           state_q, state_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  valid_q, valid_d;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      addr_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      addr_q  <= addr_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    addr_d  = addr_q;
    valid_d = valid_q;

    // Abort outranks everything, including a handshake landing on the same edge.
    if (state_q != S_IDLE && Abort) begin
      state_d = S_IDLE;
      valid_d = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (Start && !Abort) begin
            state_d = S_WAIT;
            idx_d   = '0;
            cnt_d   = '0;
          end
        end
        S_WAIT: begin
          if (cnt_q == WAIT_CNT) begin
            data_d  = rf.BusA;
            addr_d  = idx_q;
            valid_d = 1'b1;
            state_d = S_HOLD;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
        S_HOLD: begin
          if (valid_q && rf.OutReady) begin
            valid_d = 1'b0;
            if (idx_q == LAST_IDX) begin
              state_d = S_DONE;
            end else begin
              idx_d   = idx_q + 1'b1;
              cnt_d   = '0;
              state_d = S_WAIT;
            end
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign rf.RA       = (state_q == S_IDLE) ? '0 : idx_q;
  assign rf.OutData  = data_q;
  assign rf.OutAddr  = addr_q;
  assign rf.OutValid = valid_q;
  assign Busy        = (state_q != S_IDLE);
  assign Done        = (state_q == S_DONE);

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Scoreboard bench for regfile_dump_reader: default build (X0..X30, one wait cycle)
// plus a LAST_REG=0 / READ_WAIT=3 build, both reading a file preloaded with 0x1000+n.
module tb_regfile_dump_reader;

  typedef struct packed {
    logic [4:0]  addr;
    logic [63:0] data;
  } beat_t;

  logic clk;
  logic rst_n;
  logic start, abort, busy, done;
  logic start2, abort2, busy2, done2;

  int vectors;
  int miscompares;
  int done_cnt;

  beat_t exp_q[$];
  beat_t exp2_q[$];

  logic        prev_valid, prev_hs;
  logic [63:0] prev_data;
  logic [4:0]  prev_addr;

  regfile_dump_reader_if #(.DATA_WIDTH(64), .ADDR_WIDTH(5)) rf  ();
  regfile_dump_reader_if #(.DATA_WIDTH(64), .ADDR_WIDTH(5)) rf2 ();

  assign rf.BusA  = 64'h1000 + 64'(rf.RA);
  assign rf2.BusA = 64'h1000 + 64'(rf2.RA);

  regfile_dump_reader #(
    .DATA_WIDTH(64), .ADDR_WIDTH(5), .LAST_REG(30), .READ_WAIT(1)
  ) dut (
    .Clk(clk), .Reset_n(rst_n), .Start(start), .Abort(abort),
    .Busy(busy), .Done(done), .rf(rf)
  );

  regfile_dump_reader #(
    .DATA_WIDTH(64), .ADDR_WIDTH(5), .LAST_REG(0), .READ_WAIT(3)
  ) dut2 (
    .Clk(clk), .Reset_n(rst_n), .Start(start2), .Abort(abort2),
    .Busy(busy2), .Done(done2), .rf(rf2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: event not as required", name);
  endtask

  task automatic push_range(input int lo, input int hi);
    for (int n = lo; n <= hi; n++) exp_q.push_back({5'(n), 64'h1000 + 64'(n)});
  endtask

  // Edges (sampled #1 after each) until OutValid of the default build is seen.
  task automatic wait_valid(output int n, input int budget);
    n = 0;
    while (!rf.OutValid && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    if (!rf.OutValid) fail_now("wait_valid_timeout");
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid <= 1'b0;
      prev_hs    <= 1'b0;
    end else begin
      if (done) done_cnt <= done_cnt + 1;
      if (rf.OutValid && prev_valid && !prev_hs) begin
        check("hold_data", rf.OutData, prev_data);
        check("hold_addr", 64'(rf.OutAddr), 64'(prev_addr));
      end
      if (rf.OutValid && rf.OutReady && !abort) begin
        if (exp_q.size() == 0) fail_now("unexpected_beat");
        else begin
          check("beat_addr", 64'(rf.OutAddr), 64'(exp_q[0].addr));
          check("beat_data", rf.OutData, exp_q[0].data);
          exp_q.delete(0);
        end
      end
      prev_valid <= rf.OutValid;
      prev_hs    <= rf.OutValid && rf.OutReady && !abort;
      prev_data  <= rf.OutData;
      prev_addr  <= rf.OutAddr;
    end
  end

  always @(negedge clk) begin
    if (rst_n && rf2.OutValid && rf2.OutReady && !abort2) begin
      if (exp2_q.size() == 0) fail_now("unexpected_beat2");
      else begin
        check("beat2_addr", 64'(rf2.OutAddr), 64'(exp2_q[0].addr));
        check("beat2_data", rf2.OutData, exp2_q[0].data);
        exp2_q.delete(0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int d0;
    vectors = 0; miscompares = 0; done_cnt = 0;
    rst_n = 1'b0;
    start = 1'b0; abort = 1'b0; start2 = 1'b0; abort2 = 1'b0;
    rf.OutReady = 1'b0; rf2.OutReady = 1'b0;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_RA", 64'(rf.RA), 64'h0);
    check("rst_OutData", rf.OutData, 64'h0);
    check("rst_OutAddr", 64'(rf.OutAddr), 64'h0);
    check("rst_OutValid", 64'(rf.OutValid), 64'h0);
    check("rst_Busy", 64'(busy), 64'h0);
    check("rst_Done", 64'(done), 64'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Full dump with OutReady high; Start re-pulsed mid-dump is ignored
    d0 = done_cnt;
    push_range(0, 30);
    rf.OutReady = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("start_busy", 64'(busy), 64'h1);
    check("start_RA", 64'(rf.RA), 64'h0);
    wait_valid(n, 20);
    check("first_valid_latency", 64'(n), 64'd2);
    for (int b = 1; b <= 30; b++) begin
      if (b == 10) start = 1'b1;
      if (b == 12) start = 1'b0;
      @(posedge clk); #1;
      wait_valid(n, 20);
      check("beat_gap", 64'(n + 1), 64'd3);
    end
    @(posedge clk); #1;
    check("done_high", 64'(done), 64'h1);
    check("done_busy", 64'(busy), 64'h1);
    check("done_valid", 64'(rf.OutValid), 64'h0);
    @(posedge clk); #1;
    check("post_done", 64'(done), 64'h0);
    check("post_busy", 64'(busy), 64'h0);
    repeat (4) @(posedge clk);
    #1;
    check("done_pulses_full", 64'(done_cnt - d0), 64'd1);
    check("full_queue_empty", 64'(exp_q.size()), 64'd0);

    // Abort while holding index 7, with OutReady high on the same edge
    d0 = done_cnt;
    rf.OutReady = 1'b0;
    push_range(0, 6);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int b = 0; b < 7; b++) begin
      wait_valid(n, 20);
      rf.OutReady = 1'b1;
      @(posedge clk); #1;
      rf.OutReady = 1'b0;
    end
    wait_valid(n, 20);
    check("abort_hold_addr", 64'(rf.OutAddr), 64'd7);
    abort = 1'b1;
    rf.OutReady = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    rf.OutReady = 1'b0;
    check("abort_valid", 64'(rf.OutValid), 64'h0);
    check("abort_busy", 64'(busy), 64'h0);
    check("abort_done", 64'(done), 64'h0);

    // Start and Abort together in IDLE stay IDLE
    start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    check("start_abort_idle", 64'(busy), 64'h0);
    repeat (3) @(posedge clk);
    #1;
    check("start_abort_still_idle", 64'(busy), 64'h0);
    check("abort_no_done", 64'(done_cnt - d0), 64'd0);
    check("abort_queue_empty", 64'(exp_q.size()), 64'd0);

    // Fresh dump from index 0 with OutReady toggling
    d0 = done_cnt;
    push_range(0, 30);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("restart_RA", 64'(rf.RA), 64'h0);
    n = 0;
    while (!done && n < 2000) begin
      rf.OutReady = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      n++;
    end
    if (!done) fail_now("random_done_timeout");
    rf.OutReady = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("random_done_pulses", 64'(done_cnt - d0), 64'd1);
    check("random_queue_empty", 64'(exp_q.size()), 64'd0);

    // Asynchronous reset between edges while in WAIT
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_RA", 64'(rf.RA), 64'h0);
    check("arst_OutData", rf.OutData, 64'h0);
    check("arst_OutAddr", 64'(rf.OutAddr), 64'h0);
    check("arst_OutValid", 64'(rf.OutValid), 64'h0);
    check("arst_Busy", 64'(busy), 64'h0);
    check("arst_Done", 64'(done), 64'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("arst_stays_idle", 64'(busy), 64'h0);

    // LAST_REG=0, READ_WAIT=3: single beat
    exp2_q.push_back({5'd0, 64'h1000});
    rf2.OutReady = 1'b1;
    start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    check("lr0_busy", 64'(busy2), 64'h1);
    n = 0;
    while (!rf2.OutValid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("lr0_valid_latency", 64'(n), 64'd4);
    check("lr0_addr", 64'(rf2.OutAddr), 64'd0);
    @(posedge clk); #1;
    check("lr0_done", 64'(done2), 64'h1);
    check("lr0_valid_clear", 64'(rf2.OutValid), 64'h0);
    @(posedge clk); #1;
    check("lr0_done_fall", 64'(done2), 64'h0);
    check("lr0_busy_fall", 64'(busy2), 64'h0);
    repeat (3) @(posedge clk);
    #1;
    check("lr0_queue_empty", 64'(exp2_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
